// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester round-robin arbiter and sequencer for the memory bus
// Grants one requester, holds READ/WRITE for MEM_LATENCY cycles, then pulses DONE with read data.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  busy_q, busy_d;
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // On a tie the requester that was not served last wins.
  assign win       = (REQ0 & REQ1) ? ~last_q : REQ1;
  assign win_we    = win ? WE1 : WE0;
  assign win_addr  = win ? ADDR1 : ADDR0;
  assign win_wdata = win ? WDATA1 : WDATA0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (REQ0 | REQ1) begin
          owner_d     = win;
          last_d      = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          mem_addr_d  = win_addr;
          mem_read_d  = ~win_we;
          mem_write_d = win_we;
          mem_wdata_d = win_we ? win_wdata : '0;
          cnt_d       = CNT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (mem_read_q) rdata_d = MEM_RDATA;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_wdata_d = '0;
          done0_d     = ~owner_q;
          done1_d     = owner_q;
          state_d     = COMPLETE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign DONE0     = done0_q;
  assign DONE1     = done1_q;
  assign BUSY      = busy_q;
  assign RDATA     = rdata_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        CLK, RST;
  logic        REQ0, REQ1, WE0, WE1;
  logic [25:0] ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1, MEM_RDATA;
  logic        GNT0, GNT1, DONE0, DONE1, BUSY, MEM_READ, MEM_WRITE;
  logic [31:0] RDATA, MEM_WDATA;
  logic [25:0] MEM_ADDR;

  logic        req_l1, req_l15;
  logic        l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_busy, l1_read, l1_write;
  logic [31:0] l1_rdata, l1_wdata;
  logic [25:0] l1_addr;
  logic        l15_gnt0, l15_gnt1, l15_done0, l15_done1, l15_busy, l15_read, l15_write;
  logic [31:0] l15_rdata, l15_wdata;
  logic [25:0] l15_addr;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(26), .MEM_LATENCY(2)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .RDATA(RDATA),
    .BUSY(BUSY), .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(26), .MEM_LATENCY(1)) u_l1 (
    .CLK(CLK), .RST(RST), .REQ0(req_l1), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(l1_gnt0), .GNT1(l1_gnt1), .DONE0(l1_done0), .DONE1(l1_done1), .RDATA(l1_rdata),
    .BUSY(l1_busy), .MEM_ADDR(l1_addr), .MEM_READ(l1_read), .MEM_WRITE(l1_write),
    .MEM_WDATA(l1_wdata), .MEM_RDATA(MEM_RDATA)
  );

  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(26), .MEM_LATENCY(15)) u_l15 (
    .CLK(CLK), .RST(RST), .REQ0(req_l15), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(l15_gnt0), .GNT1(l15_gnt1), .DONE0(l15_done0), .DONE1(l15_done1), .RDATA(l15_rdata),
    .BUSY(l15_busy), .MEM_ADDR(l15_addr), .MEM_READ(l15_read), .MEM_WRITE(l15_write),
    .MEM_WDATA(l15_wdata), .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    REQ0 = 0; REQ1 = 0; req_l1 = 0; req_l15 = 0;
    RST = 1;
    tick;
    RST = 0;
  endtask

  task automatic test_reset;
    RST = 1;
    #1;
    checks++;
    if ({GNT0, GNT1, DONE0, DONE1, BUSY, MEM_READ, MEM_WRITE} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {GNT0, GNT1, DONE0, DONE1, BUSY, MEM_READ, MEM_WRITE});
    end
    checks++;
    if ({MEM_ADDR, MEM_WDATA, RDATA} !== 90'b0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", MEM_ADDR, MEM_WDATA, RDATA);
    end
    tick;
    RST = 0;
  endtask

  task automatic test_read;
    REQ0 = 1; WE0 = 0; ADDR0 = 26'h0000010; MEM_RDATA = 32'hDEADBEEF;
    tick;
    checks++;
    if ({GNT0, GNT1, MEM_READ, MEM_WRITE, BUSY, DONE0} !== 6'b101010 || MEM_ADDR !== 26'h10) begin
      failures++; $display("FAIL read_grant got=%b addr=%h exp=101010 addr=10", {GNT0, GNT1, MEM_READ, MEM_WRITE, BUSY, DONE0}, MEM_ADDR);
    end
    tick;
    checks++;
    if ({GNT0, MEM_READ, DONE0} !== 3'b010 || MEM_ADDR !== 26'h10) begin
      failures++; $display("FAIL read_hold got=%b addr=%h exp=010 addr=10", {GNT0, MEM_READ, DONE0}, MEM_ADDR);
    end
    tick;
    checks++;
    if ({MEM_READ, DONE0, DONE1} !== 3'b010 || RDATA !== 32'hDEADBEEF) begin
      failures++; $display("FAIL read_done got=%b rdata=%h exp=010 rdata=deadbeef", {MEM_READ, DONE0, DONE1}, RDATA);
    end
    REQ0 = 0;
    tick;
    checks++;
    if ({DONE0, BUSY} !== 2'b00 || RDATA !== 32'hDEADBEEF) begin
      failures++; $display("FAIL read_idle got=%b rdata=%h exp=00 rdata=deadbeef", {DONE0, BUSY}, RDATA);
    end
  endtask

  task automatic test_write;
    REQ1 = 1; WE1 = 1; ADDR1 = 26'h3FFFFFF; WDATA1 = 32'h12345678; MEM_RDATA = 32'hCAFEF00D;
    tick;
    checks++;
    if ({GNT0, GNT1, MEM_READ, MEM_WRITE} !== 4'b0101 || MEM_ADDR !== 26'h3FFFFFF || MEM_WDATA !== 32'h12345678) begin
      failures++; $display("FAIL write_grant got=%b addr=%h wdata=%h exp=0101 3ffffff 12345678", {GNT0, GNT1, MEM_READ, MEM_WRITE}, MEM_ADDR, MEM_WDATA);
    end
    tick;
    checks++;
    if ({GNT1, MEM_WRITE, DONE1} !== 3'b010 || MEM_WDATA !== 32'h12345678) begin
      failures++; $display("FAIL write_hold got=%b wdata=%h exp=010 12345678", {GNT1, MEM_WRITE, DONE1}, MEM_WDATA);
    end
    tick;
    checks++;
    if ({MEM_WRITE, DONE0, DONE1} !== 3'b001 || MEM_WDATA !== 32'h0 || RDATA !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_done got=%b wdata=%h rdata=%h exp=001 0 deadbeef", {MEM_WRITE, DONE0, DONE1}, MEM_WDATA, RDATA);
    end
    REQ1 = 0;
    tick;
    checks++;
    if ({DONE1, BUSY} !== 2'b00) begin
      failures++; $display("FAIL write_idle got=%b exp=00", {DONE1, BUSY});
    end
  endtask

  // Both requests held: G0@1 D0@3 G1@5 D1@7 G0@9 D0@11 G1@13 D1@15.
  task automatic test_back_to_back;
    logic [3:0] exp;
    do_reset;
    WE0 = 0; WE1 = 0; REQ0 = 1; REQ1 = 1;
    for (int c = 1; c <= 16; c++) begin
      tick;
      exp = {(c == 1 || c == 9), (c == 5 || c == 13), (c == 3 || c == 11), (c == 7 || c == 15)};
      checks++;
      if ({GNT0, GNT1, DONE0, DONE1} !== exp) begin
        failures++; $display("FAIL rr_cycle%0d got=%b exp=%b", c, {GNT0, GNT1, DONE0, DONE1}, exp);
      end
      checks++;
      if ((GNT0 && GNT1) || (MEM_READ && MEM_WRITE) || (DONE0 && DONE1)) begin
        failures++; $display("FAIL rr_exclusive_cycle%0d got=%b exp=no pair", c, {GNT0, GNT1, MEM_READ, MEM_WRITE, DONE0, DONE1});
      end
    end
    REQ0 = 0; REQ1 = 0;
  endtask

  task automatic test_reset_mid_access;
    do_reset;
    REQ0 = 1; WE0 = 0; ADDR0 = 26'h10;
    tick;
    tick;
    checks++;
    if (MEM_READ !== 1'b1) begin
      failures++; $display("FAIL abort_pre got=%b exp=1", MEM_READ);
    end
    #2 RST = 1; REQ0 = 0;
    #1;
    checks++;
    if ({MEM_READ, MEM_WRITE, BUSY, GNT0, DONE0} !== 5'b0) begin
      failures++; $display("FAIL abort_async got=%b exp=00000", {MEM_READ, MEM_WRITE, BUSY, GNT0, DONE0});
    end
    tick;
    RST = 0;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++;
      if ({DONE0, DONE1, BUSY} !== 3'b000) begin
        failures++; $display("FAIL abort_no_done%0d got=%b exp=000", c, {DONE0, DONE1, BUSY});
      end
    end
    REQ0 = 1; REQ1 = 1;
    tick;
    checks++;
    if ({GNT0, GNT1} !== 2'b10) begin
      failures++; $display("FAIL abort_tie got=%b exp=10", {GNT0, GNT1});
    end
    REQ0 = 0; REQ1 = 0;
  endtask

  task automatic test_held_inputs;
    do_reset;
    REQ0 = 1; WE0 = 0; ADDR0 = 26'h10; WDATA0 = 32'h0;
    tick;
    checks++;
    if (GNT0 !== 1'b1) begin
      failures++; $display("FAIL held_gnt got=%b exp=1", GNT0);
    end
    ADDR0 = 26'h20; WE0 = 1; WDATA0 = 32'hFFFF0000; REQ0 = 0;
    tick;
    checks++;
    if (MEM_ADDR !== 26'h10 || {MEM_READ, MEM_WRITE} !== 2'b10 || MEM_WDATA !== 32'h0) begin
      failures++; $display("FAIL held_addr got=%h %b %h exp=10 10 0", MEM_ADDR, {MEM_READ, MEM_WRITE}, MEM_WDATA);
    end
    tick;
    checks++;
    if (DONE0 !== 1'b1 || MEM_ADDR !== 26'h10) begin
      failures++; $display("FAIL held_done got=%b addr=%h exp=1 addr=10", DONE0, MEM_ADDR);
    end
    tick;
  endtask

  task automatic test_latency_sweep;
    int g1, d1, w1, g15, d15, w15;
    g1 = -1; d1 = -1; w1 = 0; g15 = -1; d15 = -1; w15 = 0;
    do_reset;
    ADDR0 = 26'h5;
    req_l1 = 1; req_l15 = 1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (l1_gnt0 && g1 < 0) g1 = c;
      if (l1_read) w1++;
      if (l1_done0 && d1 < 0) begin d1 = c; req_l1 = 0; end
      if (l15_gnt0 && g15 < 0) g15 = c;
      if (l15_read) w15++;
      if (l15_done0 && d15 < 0) begin d15 = c; req_l15 = 0; end
    end
    checks++;
    if (d1 < 0 || d15 < 0) begin
      failures++; $display("FAIL sweep_timeout got=%0d/%0d exp=done seen", d1, d15);
    end
    checks++;
    if (w1 != 1 || d1 - g1 != 1) begin
      failures++; $display("FAIL sweep_l1 got width=%0d spacing=%0d exp=1/1", w1, d1 - g1);
    end
    checks++;
    if (w15 != 15 || d15 - g15 != 15) begin
      failures++; $display("FAIL sweep_l15 got width=%0d spacing=%0d exp=15/15", w15, d15 - g15);
    end
  endtask

  initial begin
    RST = 1; REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; MEM_RDATA = '0;
    req_l1 = 0; req_l15 = 0;
    #12;
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_reset_mid_access;
    test_held_inputs;
    test_latency_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
